// File: rtl/wb_pattern_pkg.sv
// Shared definitions for the Wishbone pattern tester: FSM state encoding and
// the Wishbone cycle-type identifiers driven on wb_cti_o.
package wb_pattern_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_INIT,
        WR_BURST,
        WR_GAP,
        RD_BURST,
        RD_GAP,
        FIN
    } state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam int CNT_W = 16;

endpackage

// File: rtl/wbm_beat_gen.sv
// Beat generator: tracks the current beat's address, pattern data and the
// position inside the current burst and inside the whole phase.
module wbm_beat_gen
    import wb_pattern_pkg::*;
#(
    parameter int dw     = 32,
    parameter int APP_AW = 26,
    parameter int BL     = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic              i_restart,
    input  logic              i_advance,
    input  logic [APP_AW-1:0] i_base_addr,
    input  logic [CNT_W-1:0]  i_num_words,
    input  logic [dw-1:0]     i_seed,
    output logic [APP_AW-1:0] o_addr,
    output logic [dw-1:0]     o_data,
    output logic              o_last_beat,
    output logic              o_last_in_burst,
    output logic              o_zero_words
);

    localparam logic [APP_AW-1:0] STEP       = APP_AW'(dw / 8);
    localparam logic [3:0]        BURST_LAST = 4'(BL - 1);

    logic [APP_AW-1:0] r_base;
    logic [dw-1:0]     r_seed;
    logic [CNT_W-1:0]  r_num;
    logic [APP_AW-1:0] r_addr;
    logic [dw-1:0]     r_data;
    logic [CNT_W-1:0]  r_beat;
    logic [3:0]        r_burst;

    // Address and data advance incrementally so no multiplier is needed;
    // restart rewinds both to beat 0 for the read-back phase.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_base  <= '0;
            r_seed  <= '0;
            r_num   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_beat  <= '0;
            r_burst <= '0;
        end else if (i_load) begin
            r_base  <= i_base_addr;
            r_seed  <= i_seed;
            r_num   <= i_num_words;
            r_addr  <= i_base_addr;
            r_data  <= i_seed;
            r_beat  <= '0;
            r_burst <= '0;
        end else if (i_restart) begin
            r_addr  <= r_base;
            r_data  <= r_seed;
            r_beat  <= '0;
            r_burst <= '0;
        end else if (i_advance) begin
            r_addr  <= r_addr + STEP;
            r_data  <= r_data + dw'(1);
            r_beat  <= r_beat + CNT_W'(1);
            r_burst <= o_last_in_burst ? 4'd0 : r_burst + 4'd1;
        end
    end

    assign o_addr          = r_addr;
    assign o_data          = r_data;
    assign o_last_beat     = (r_beat == r_num - CNT_W'(1));
    assign o_last_in_burst = (r_burst == BURST_LAST) || o_last_beat;
    assign o_zero_words    = (r_num == '0);

endmodule

// File: rtl/wb_pattern_master.sv
// Wishbone pattern tester: writes seed+i to consecutive words in bursts,
// reads them back, counts mismatches and reports done/timeout.
module wb_pattern_master
    import wb_pattern_pkg::*;
#(
    parameter int dw     = 32,
    parameter int APP_AW = 26,
    parameter int BL     = 8,
    parameter int TMO    = 1024
) (
    input  logic              wb_clk_i,
    input  logic              wb_resetn,
    input  logic              start,
    input  logic [APP_AW-1:0] base_addr,
    input  logic [15:0]       num_words,
    input  logic [dw-1:0]     seed,
    input  logic              sdr_init_done,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [APP_AW-1:0] wb_addr_o,
    output logic [dw-1:0]     wb_dat_o,
    output logic [dw/8-1:0]   wb_sel_o,
    output logic [2:0]        wb_cti_o,
    input  logic              wb_ack_i,
    input  logic [dw-1:0]     wb_dat_i,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [15:0]       err_cnt,
    output logic [APP_AW-1:0] first_err_addr
);

    localparam int TW = $clog2(TMO + 1);

    state_t            r_state;
    state_t            w_next;
    logic [TW-1:0]     r_tmo_cnt;
    logic              r_timeout;
    logic [15:0]       r_err_cnt;
    logic [APP_AW-1:0] r_first_err_addr;

    logic              w_in_burst;
    logic              w_ack;
    logic              w_tmo;
    logic              w_load;
    logic              w_restart;
    logic              w_advance;
    logic [APP_AW-1:0] w_addr;
    logic [dw-1:0]     w_data;
    logic              w_last_beat;
    logic              w_last_in_burst;
    logic              w_zero_words;

    assign w_in_burst = (r_state == WR_BURST) || (r_state == RD_BURST);
    assign w_ack      = w_in_burst && wb_ack_i;
    assign w_tmo      = w_in_burst && !wb_ack_i && (r_tmo_cnt == TW'(TMO - 1));
    assign w_load     = (r_state == IDLE) && start;
    assign w_restart  = (r_state == WR_BURST) && w_ack && w_last_beat;
    assign w_advance  = w_ack && !w_restart;

    wbm_beat_gen #(
        .dw     (dw),
        .APP_AW (APP_AW),
        .BL     (BL)
    ) u_beat_gen (
        .i_clk           (wb_clk_i),
        .i_rst_n         (wb_resetn),
        .i_load          (w_load),
        .i_restart       (w_restart),
        .i_advance       (w_advance),
        .i_base_addr     (base_addr),
        .i_num_words     (num_words),
        .i_seed          (seed),
        .o_addr          (w_addr),
        .o_data          (w_data),
        .o_last_beat     (w_last_beat),
        .o_last_in_burst (w_last_in_burst),
        .o_zero_words    (w_zero_words)
    );

    always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
        if (!wb_resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        wb_cyc_o = w_in_burst;
        wb_stb_o = w_in_burst;
        wb_we_o  = (r_state == WR_BURST);
        wb_sel_o = {(dw/8){w_in_burst}};
        wb_cti_o = CTI_CLASSIC;
        busy     = (r_state != IDLE) && (r_state != FIN);
        done     = (r_state == FIN);
        if (w_in_burst) begin
            wb_cti_o = w_last_in_burst ? CTI_EOB : CTI_INCR;
        end
        case (r_state)
            IDLE:      if (start) w_next = WAIT_INIT;
            WAIT_INIT: if (sdr_init_done) w_next = w_zero_words ? FIN : WR_BURST;
            WR_BURST: begin
                if (w_ack) begin
                    if (w_last_beat)          w_next = RD_GAP;
                    else if (w_last_in_burst) w_next = WR_GAP;
                end else if (w_tmo) begin
                    w_next = FIN;
                end
            end
            WR_GAP:    w_next = WR_BURST;
            RD_BURST: begin
                if (w_ack) begin
                    if (w_last_beat)          w_next = FIN;
                    else if (w_last_in_burst) w_next = RD_GAP;
                end else if (w_tmo) begin
                    w_next = FIN;
                end
            end
            RD_GAP:    w_next = RD_BURST;
            FIN:       w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // Timeout counter measures consecutive unacknowledged strobe cycles;
    // the first mismatch address is captured while the error count is still zero.
    always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
        if (!wb_resetn) begin
            r_tmo_cnt        <= '0;
            r_timeout        <= 1'b0;
            r_err_cnt        <= '0;
            r_first_err_addr <= '0;
        end else begin
            r_tmo_cnt <= (w_in_burst && !wb_ack_i) ? r_tmo_cnt + TW'(1) : '0;
            if (w_load) begin
                r_timeout        <= 1'b0;
                r_err_cnt        <= '0;
                r_first_err_addr <= '0;
            end else begin
                if (w_tmo) r_timeout <= 1'b1;
                if ((r_state == RD_BURST) && w_ack && (wb_dat_i != w_data)) begin
                    if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
                    if (r_err_cnt == 16'd0)    r_first_err_addr <= w_addr;
                end
            end
        end
    end

    assign wb_addr_o      = w_addr;
    assign wb_dat_o       = w_data;
    assign timeout        = r_timeout;
    assign err_cnt        = r_err_cnt;
    assign first_err_addr = r_first_err_addr;

endmodule
